led_breath_sched: RTL
=====================

LED_BREATH_SCHED -- requirements
Module: led_breath_sched

Interface
REQ-001 SHALL have parameter PERIOD_CYC, default 500_000, PWM period in clk cycles (10 ms at 50 MHz).
REQ-002 SHALL have parameter STEPS, default 20, duty steps per ramp; DUTY_INC = PERIOD_CYC/STEPS, and PERIOD_CYC SHALL be an exact multiple of STEPS.
REQ-003 SHALL have parameter PERIODS_PER_STEP, default 10, PWM periods per duty step.
REQ-004 SHALL have parameter HOLD_STEPS, default 10, steps held at full duty.
REQ-005 SHALL have ports: clk  in  1  clock; reset rst_n, asynchronous, active-low; clock clk.
REQ-006 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have port en  in  1  level; run the sequence while high.
REQ-008 SHALL have port pause  in  1  level; freeze the step sequence while high.
REQ-009 SHALL have port ch_mask  in  4  channels eligible for breathing.
REQ-010 SHALL have port led  out  4  registered PWM drive, active-high.
REQ-011 SHALL have port cur_ch  out  2  channel currently breathing.
REQ-012 SHALL have port busy  out  1  high in UP, HOLD and DOWN.

Function
REQ-013 SHALL run a period counter 0..PERIOD_CYC-1 that wraps freely whenever state != IDLE; period_end is asserted at count PERIOD_CYC-1.
REQ-014 SHALL latch the duty register into the active duty only at period_end, so no period mixes two duties.
REQ-015 SHALL drive led[cur_ch] = 1 when period count < active duty, else 0, with one-cycle register latency; all other led bits SHALL be 0.
REQ-016 SHALL count period_end events 0..PERIODS_PER_STEP-1 and assert step_tick at wrap; the counter and step_tick SHALL freeze while pause=1, while the PWM continues at the current duty.
REQ-017 SHALL implement FSM states IDLE, SELECT, UP, HOLD and DOWN.
REQ-018 IDLE: duty=0, counters cleared, led=0; SHALL go to SELECT when en=1.
REQ-019 SELECT (one cycle): SHALL choose the first set bit of ch_mask searching cur_ch+1, cur_ch+2, ... with wrap, then cur_ch itself; load cur_ch, duty=0, and go to UP; if ch_mask=0, SHALL go to IDLE.
REQ-020 UP: on each step_tick, duty += DUTY_INC; when duty reaches STEPS*DUTY_INC (=PERIOD_CYC), SHALL go to HOLD.
REQ-021 HOLD: SHALL count HOLD_STEPS step_ticks, then go to DOWN.
REQ-022 DOWN: on each step_tick, duty -= DUTY_INC; when duty reaches 0, SHALL go to SELECT.
REQ-023 Duty arithmetic SHALL be unsigned, clog2(PERIOD_CYC+1) bits wide, and never exceed PERIOD_CYC or underflow below 0.
REQ-024 en falling in any non-IDLE state SHALL force IDLE at the next period_end, with led=0 from then on.
REQ-025 A ch_mask change SHALL take effect only at the next SELECT; the current channel SHALL complete its cycle.
REQ-026 step_tick coinciding with an en-low exit SHALL be ignored in favour of the IDLE transition.

Reset
REQ-027 rst_n low SHALL asynchronously set: state=IDLE, all counters 0, duty 0, active duty 0, led=4'b0000, cur_ch=2'd3 (so the first SELECT starts its search at ch0), busy=0.
REQ-028 Reset release SHALL take effect on the first clk edge after deassertion; there SHALL be no other initialization.

Structure
REQ-029 The FSM state enum and default timing constants (PERIOD_CYC, STEPS, PERIODS_PER_STEP, HOLD_STEPS) SHALL live in shared package led_pkg.
REQ-030 The period counter and comparator SHALL be one sub-module, pwm_core (inputs: duty, enable; outputs: pwm, period_end); led_breath_sched SHALL contain the FSM, step timing and channel select.

Verification (PERIOD_CYC=10, STEPS=5, DUTY_INC=2, PERIODS_PER_STEP=2, HOLD_STEPS=2)
REQ-031 Reset then en=1, ch_mask=4'b0001: cur_ch=0 SHALL hold; the led[0] high time per period SHALL step 0,2,4,6,8,10 every 20 cycles, hold 10 for 40 cycles, then fall 8..0; busy SHALL be 1 throughout.
REQ-032 ch_mask=4'b1010: successive cycles SHALL run on cur_ch 1,3,1,3; led[0] and led[2] SHALL stay 0.
REQ-033 pause=1 for 50 cycles during UP at duty 4: led high time SHALL stay 4 each period, and ramping SHALL resume on release without a skipped step.
REQ-034 en=0 mid-HOLD: led SHALL go 0 and busy 0 at the next period_end, with state IDLE; en=1 again SHALL restart from SELECT.
REQ-035 ch_mask=0 with en=1: SELECT SHALL return to IDLE, led=0 and busy=0; rst_n pulsed mid-DOWN SHALL clear all outputs immediately, without waiting for clk.

Source files
------------

// File: rtl/led_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg
// Shared definitions for the LED breathing scheduler:
//   - state_t       : scheduler FSM states
//   - DEF_*         : default timing constants (50 MHz clock, 10 ms PWM period)
//   - ch_pick_t     : result of the round-robin channel search
//   - pick_next_ch  : finds the next eligible channel after the current one
// ---------------------------------------------------------------------------
package led_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_UP,
        ST_HOLD,
        ST_DOWN
    } state_t;

    localparam int DEF_PERIOD_CYC       = 500_000;
    localparam int DEF_STEPS            = 20;
    localparam int DEF_PERIODS_PER_STEP = 10;
    localparam int DEF_HOLD_STEPS       = 10;

    typedef struct packed {
        logic       found;
        logic [1:0] ch;
    } ch_pick_t;

    // Search cur+1, cur+2, cur+3 (mod 4) and finally cur itself. The loop
    // walks from the farthest candidate to the nearest so the nearest set
    // bit is the one left in the result.
    function automatic ch_pick_t pick_next_ch(input logic [3:0] mask,
                                              input logic [1:0] cur);
        ch_pick_t   r;
        logic [1:0] c;
        r.found = 1'b0;
        r.ch    = cur;
        for (int i = 4; i >= 1; i--) begin
            c = cur + 2'(i);
            if (mask[c]) begin
                r.found = 1'b1;
                r.ch    = c;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pwm_core.sv
// ---------------------------------------------------------------------------
// pwm_core
// Free-running PWM period counter with duty comparator.
//   clk, rst_n  : clock, asynchronous active-low reset
//   enable      : counter runs while high; counter and active duty clear when low
//   duty        : requested duty (high cycles per period), sampled at period end
//   pwm         : combinational compare (count < active duty); the caller
//                 registers it
//   period_end  : high on the last count of each period
// ---------------------------------------------------------------------------
module pwm_core
    import led_pkg::*;
#(
    parameter int PERIOD_CYC = DEF_PERIOD_CYC,
    parameter int DUTY_W     = $clog2(PERIOD_CYC + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [DUTY_W-1:0] duty,
    output logic              pwm,
    output logic              period_end
);

    localparam int               CNT_W    = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_CYC - 1);

    logic [CNT_W-1:0]  cnt;
    logic [DUTY_W-1:0] active_duty;

    assign period_end = enable && (cnt == CNT_LAST);
    assign pwm        = enable && (DUTY_W'(cnt) < active_duty);

    // Active duty only changes on the period boundary so every period is
    // driven with a single duty value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            active_duty <= '0;
        end else if (!enable) begin
            cnt         <= '0;
            active_duty <= '0;
        end else if (period_end) begin
            cnt         <= '0;
            active_duty <= duty;
        end else begin
            cnt         <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_breath_sched.sv
// ---------------------------------------------------------------------------
// led_breath_sched
// Breathes one LED channel at a time: duty ramps up, holds at full, ramps
// down, then the next eligible channel (round robin over ch_mask) starts.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : run the sequence while high; low stops at the next period end
//   pause      : freeze step timing (PWM keeps running at the current duty)
//   ch_mask    : channels eligible for breathing, sampled only when selecting
//   led        : registered PWM drive, only led[cur_ch] can be high
//   cur_ch     : channel currently breathing
//   busy       : high while ramping up, holding or ramping down
// ---------------------------------------------------------------------------
module led_breath_sched
    import led_pkg::*;
#(
    parameter int PERIOD_CYC       = DEF_PERIOD_CYC,
    parameter int STEPS            = DEF_STEPS,
    parameter int PERIODS_PER_STEP = DEF_PERIODS_PER_STEP,
    parameter int HOLD_STEPS       = DEF_HOLD_STEPS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       pause,
    input  logic [3:0] ch_mask,
    output logic [3:0] led,
    output logic [1:0] cur_ch,
    output logic       busy
);

    localparam int DUTY_W   = $clog2(PERIOD_CYC + 1);
    localparam int DUTY_INC = PERIOD_CYC / STEPS;
    localparam int STEP_W   = (PERIODS_PER_STEP > 1) ? $clog2(PERIODS_PER_STEP) : 1;
    localparam int HOLD_W   = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

    localparam logic [DUTY_W-1:0] DUTY_FULL = DUTY_W'(PERIOD_CYC);
    localparam logic [DUTY_W-1:0] INC       = DUTY_W'(DUTY_INC);
    localparam logic [DUTY_W-1:0] LAST_UP   = DUTY_W'(PERIOD_CYC - DUTY_INC);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(PERIODS_PER_STEP - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);

    state_t            state, state_nxt;
    logic [DUTY_W-1:0] duty, duty_nxt;
    logic [1:0]        cur_ch_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic [STEP_W-1:0] step_cnt;
    logic              running;
    logic              period_end;
    logic              pwm;
    logic              step_tick;
    ch_pick_t          pick;

    assign running   = (state == ST_UP) || (state == ST_HOLD) || (state == ST_DOWN);
    assign busy      = running;
    assign step_tick = running && period_end && !pause && (step_cnt == STEP_LAST);
    assign pick      = pick_next_ch(ch_mask, cur_ch);

    // The core latches duty_nxt: duty only moves on period_end, so this is
    // the value the duty register holds for the whole coming period.
    pwm_core #(
        .PERIOD_CYC (PERIOD_CYC),
        .DUTY_W     (DUTY_W)
    ) u_pwm (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (state != ST_IDLE),
        .duty       (duty_nxt),
        .pwm        (pwm),
        .period_end (period_end)
    );

    // Periods within a step; frozen by pause.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_cnt <= '0;
        end else if (!running) begin
            step_cnt <= '0;
        end else if (period_end && !pause) begin
            step_cnt <= (step_cnt == STEP_LAST) ? '0 : step_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            duty     <= '0;
            cur_ch   <= 2'd3;
            hold_cnt <= '0;
            led      <= 4'b0000;
        end else begin
            state    <= state_nxt;
            duty     <= duty_nxt;
            cur_ch   <= cur_ch_nxt;
            hold_cnt <= hold_nxt;
            led      <= (state_nxt != ST_IDLE && pwm) ? (4'b0001 << cur_ch) : 4'b0000;
        end
    end

    always_comb begin
        state_nxt  = state;
        duty_nxt   = duty;
        cur_ch_nxt = cur_ch;
        hold_nxt   = hold_cnt;
        case (state)
            ST_IDLE: begin
                duty_nxt = '0;
                hold_nxt = '0;
                if (en) state_nxt = ST_SELECT;
            end
            ST_SELECT: begin
                duty_nxt = '0;
                hold_nxt = '0;
                if (pick.found) begin
                    cur_ch_nxt = pick.ch;
                    state_nxt  = ST_UP;
                end else begin
                    state_nxt  = ST_IDLE;
                end
            end
            ST_UP: begin
                if (step_tick) begin
                    if (duty >= LAST_UP) begin
                        duty_nxt  = DUTY_FULL;
                        hold_nxt  = '0;
                        state_nxt = ST_HOLD;
                    end else begin
                        duty_nxt  = duty + INC;
                    end
                end
            end
            ST_HOLD: begin
                // The tick that ends the hold is also the first down step,
                // so full duty lasts exactly HOLD_STEPS steps.
                if (step_tick) begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_nxt = '0;
                        if (duty > INC) begin
                            duty_nxt  = duty - INC;
                            state_nxt = ST_DOWN;
                        end else begin
                            duty_nxt  = '0;
                            state_nxt = ST_SELECT;
                        end
                    end else begin
                        hold_nxt = hold_cnt + 1'b1;
                    end
                end
            end
            ST_DOWN: begin
                if (step_tick) begin
                    if (duty > INC) begin
                        duty_nxt  = duty - INC;
                    end else begin
                        duty_nxt  = '0;
                        state_nxt = ST_SELECT;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                duty_nxt  = '0;
            end
        endcase
        // Stopping wins over any step_tick on the same period boundary.
        if (state != ST_IDLE && !en && period_end) begin
            state_nxt = ST_IDLE;
            duty_nxt  = '0;
            hold_nxt  = '0;
        end
    end

endmodule
